// File: rtl/ext_uart_pkg.sv
// Shared definitions for the ext_uart bus-attached 8N1 UART.
package ext_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_IDLE    = 1;
  localparam int ST_RX_AVAIL   = 2;
  localparam int ST_RX_OVR     = 3;
  localparam int ST_FRAME_ERR  = 4;
  localparam int ST_RX_CNT_LSB = 8;

  localparam logic [15:0] DIV_MIN = 16'd4;

  // state | meaning: IDLE line high | START start bit | DATA 8 bits LSB first | STOP stop bit
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/ext_uart_if.sv
// External-bus slave port bundle for ext_uart.
interface ext_uart_if;
  logic [15:0] i_addr;
  logic        i_stb;
  logic [3:0]  i_we;
  logic        o_ack;
  logic [31:0] i_dat_w;
  logic [31:0] o_dat_r;

  modport master (output i_addr, i_stb, i_we, i_dat_w, input o_ack, o_dat_r);
  modport slave  (input i_addr, i_stb, i_we, i_dat_w, output o_ack, o_dat_r);
endinterface

// File: rtl/ext_uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // A pop frees the slot, so a push into a full FIFO is legal in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/ext_uart.sv
// Memory-mapped 8N1 UART: bus decode, TX/RX FSMs, RX synchronizer, sticky error flags.
module ext_uart
  import ext_uart_pkg::*;
#(
  parameter int DIV_RESET  = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic      i_clk,
  input  logic      i_rst,
  ext_uart_if.slave bus,
  input  logic      i_rx,
  output logic      o_tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // bus side
  logic        r_ack;
  logic [31:0] r_dat_r;
  logic [15:0] r_div;
  logic        r_rx_ovr;
  logic        r_frame_err;
  logic        w_accept;
  logic        w_wr;
  logic [1:0]  w_reg;
  logic [31:0] w_status;
  logic [31:0] w_rd_data;
  logic        w_tx_push;
  logic        w_rx_pop;
  logic        w_clr_ovr;
  logic        w_clr_ferr;

  // fifos
  logic [7:0]    w_tx_head;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic [CW-1:0] w_tx_count;
  logic [7:0]    w_rx_head;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic [CW-1:0] w_rx_count;

  // tx
  tx_state_t   r_tx_state;
  tx_state_t   w_tx_nxt;
  logic [15:0] r_tx_cnt;
  logic [15:0] r_tx_div;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        w_tx_tc;
  logic        w_tx_load;
  logic        w_tx_line;

  // rx
  rx_state_t   r_rx_state;
  rx_state_t   w_rx_nxt;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_d;
  logic [15:0] r_rx_cnt;
  logic [15:0] r_rx_div;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        w_rx_line;
  logic        w_rx_fall;
  logic        w_rx_tc;
  logic        w_rx_start;
  logic        w_rx_push;
  logic        w_set_ovr;
  logic        w_set_ferr;

  logic        w_unused;

  assign w_unused = ^{bus.i_addr[15:4], bus.i_addr[1:0], bus.i_dat_w[31:16], w_tx_count};

  assign w_accept   = bus.i_stb & ~r_ack;
  assign w_wr       = |bus.i_we;
  assign w_reg      = bus.i_addr[3:2];
  assign w_tx_push  = w_accept & w_wr & (w_reg == REG_DATA) & ~w_tx_full;
  assign w_rx_pop   = w_accept & ~w_wr & (w_reg == REG_DATA) & ~w_rx_empty;
  assign w_clr_ovr  = w_accept & w_wr & (w_reg == REG_STATUS) & bus.i_dat_w[ST_RX_OVR];
  assign w_clr_ferr = w_accept & w_wr & (w_reg == REG_STATUS) & bus.i_dat_w[ST_FRAME_ERR];

  always_comb begin
    w_status                          = '0;
    w_status[ST_TX_FULL]              = w_tx_full;
    w_status[ST_TX_IDLE]              = w_tx_empty & (r_tx_state == TX_IDLE);
    w_status[ST_RX_AVAIL]             = ~w_rx_empty;
    w_status[ST_RX_OVR]               = r_rx_ovr;
    w_status[ST_FRAME_ERR]            = r_frame_err;
    w_status[ST_RX_CNT_LSB +: 5]      = 5'(w_rx_count);
  end

  always_comb begin
    w_rd_data = '0;
    case (w_reg)
      REG_DATA:   w_rd_data = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
      REG_STATUS: w_rd_data = w_status;
      REG_DIV:    w_rd_data = {16'd0, r_div};
      default:    w_rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack       <= 1'b0;
      r_dat_r     <= '0;
      r_div       <= 16'(DIV_RESET);
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_ack       <= w_accept;
      r_dat_r     <= (w_accept & ~w_wr) ? w_rd_data : 32'd0;
      if (w_accept & w_wr & (w_reg == REG_DIV)) r_div <= clamp_div(bus.i_dat_w[15:0]);
      // set wins over a same-cycle clear
      r_rx_ovr    <= (r_rx_ovr & ~w_clr_ovr) | w_set_ovr;
      r_frame_err <= (r_frame_err & ~w_clr_ferr) | w_set_ferr;
    end
  end

  assign bus.o_ack   = r_ack;
  assign bus.o_dat_r = r_dat_r;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_tx_push),
    .i_data  (bus.i_dat_w[7:0]),
    .i_pop   (w_tx_load),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_rx_push),
    .i_data  (r_rx_shift),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  // ---------------- TX ----------------
  assign w_tx_tc = (r_tx_cnt == 16'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_tx_state <= TX_IDLE;
    else       r_tx_state <= w_tx_nxt;
  end

  always_comb begin
    w_tx_nxt = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (!w_tx_empty) w_tx_nxt = TX_START;
      TX_START: if (w_tx_tc) w_tx_nxt = TX_DATA;
      TX_DATA:  if (w_tx_tc && r_tx_bit == 3'd7) w_tx_nxt = TX_STOP;
      TX_STOP:  if (w_tx_tc) w_tx_nxt = w_tx_empty ? TX_IDLE : TX_START;
      default:  w_tx_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    w_tx_line = 1'b1;
    w_tx_load = 1'b0;
    case (r_tx_state)
      TX_IDLE:  w_tx_load = !w_tx_empty;
      TX_START: w_tx_line = 1'b0;
      TX_DATA:  w_tx_line = r_tx_shift[0];
      TX_STOP:  w_tx_load = w_tx_tc && !w_tx_empty;
      default:  w_tx_line = 1'b1;
    endcase
  end

  // o_tx decodes the async-reset state register, so reset forces the line high at once
  assign o_tx = w_tx_line;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_cnt   <= '0;
      r_tx_div   <= DIV_MIN;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else if (w_tx_load) begin
      r_tx_shift <= w_tx_head;
      r_tx_div   <= r_div;
      r_tx_cnt   <= r_div - 16'd1;
      r_tx_bit   <= 3'd0;
    end else if (r_tx_state != TX_IDLE) begin
      if (w_tx_tc) begin
        r_tx_cnt <= r_tx_div - 16'd1;
        if (r_tx_state == TX_DATA) begin
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_bit   <= r_tx_bit + 3'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt - 16'd1;
      end
    end
  end

  // ---------------- RX ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  assign w_rx_line = r_rx_s2;
  assign w_rx_fall = r_rx_d & ~r_rx_s2;
  assign w_rx_tc   = (r_rx_cnt == 16'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rx_state <= RX_IDLE;
    else       r_rx_state <= w_rx_nxt;
  end

  always_comb begin
    w_rx_nxt = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_nxt = RX_START;
      RX_START: if (w_rx_tc) w_rx_nxt = w_rx_line ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tc && r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
      RX_STOP:  if (w_rx_tc) w_rx_nxt = RX_IDLE;
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_start = 1'b0;
    w_rx_push  = 1'b0;
    w_set_ovr  = 1'b0;
    w_set_ferr = 1'b0;
    case (r_rx_state)
      RX_IDLE: w_rx_start = w_rx_fall;
      RX_STOP: begin
        w_rx_push  = w_rx_tc & w_rx_line & ~w_rx_full;
        w_set_ovr  = w_rx_tc & w_rx_line & w_rx_full;
        w_set_ferr = w_rx_tc & ~w_rx_line;
      end
      default: w_rx_start = 1'b0;
    endcase
  end

  // first sample lands mid start bit, every later one a full bit apart
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_cnt   <= '0;
      r_rx_div   <= DIV_MIN;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else if (w_rx_start) begin
      r_rx_div <= r_div;
      r_rx_cnt <= (r_div >> 1) - 16'd1;
      r_rx_bit <= 3'd0;
    end else if (r_rx_state != RX_IDLE) begin
      if (w_rx_tc) begin
        r_rx_cnt <= r_rx_div - 16'd1;
        if (r_rx_state == RX_DATA) begin
          r_rx_shift <= {w_rx_line, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt - 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_ext_uart.sv
// Scenario bench for ext_uart: TX frames decoded off o_tx, RX frames driven onto i_rx.
module tb_ext_uart;
  localparam logic [15:0] A_DATA = 16'h0000;
  localparam logic [15:0] A_STAT = 16'h0004;
  localparam logic [15:0] A_DIV  = 16'h0008;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic tx;

  ext_uart_if u_if ();

  ext_uart #(.DIV_RESET(434), .FIFO_DEPTH(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if),
    .i_rx  (rx),
    .o_tx  (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [9:0] q_tx_exp[$];
  logic [9:0] q_tx_obs[$];
  logic [7:0] q_rx_exp[$];
  bit mon_en  = 1'b0;
  int mon_div = 4;

  // Decodes frames on o_tx into {stop, data, start}.
  initial begin : tx_mon
    logic       prev;
    logic [9:0] fr;
    int         d;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !tx) begin
        d = mon_div;
        repeat (d / 2) @(negedge clk);
        fr[0] = tx;
        for (int k = 1; k < 10; k++) begin
          repeat (d) @(negedge clk);
          fr[k] = tx;
        end
        q_tx_obs.push_back(fr);
      end
      prev = tx;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    u_if.i_addr  = a;
    u_if.i_we    = 4'hF;
    u_if.i_dat_w = d;
    u_if.i_stb   = 1'b1;
    @(negedge clk);
    u_if.i_stb = 1'b0;
    u_if.i_we  = 4'h0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    u_if.i_addr = a;
    u_if.i_we   = 4'h0;
    u_if.i_stb  = 1'b1;
    @(negedge clk);
    d = u_if.o_dat_r;
    u_if.i_stb = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (q_tx_obs.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
    @(negedge clk);
    rx = 1'b0;
    repeat (d) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (d) @(negedge clk);
    end
    rx = stop;
    repeat (d) @(negedge clk);
    rx = 1'b1;
    repeat (d) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    rx  = 1'b1;
    u_if.i_stb = 1'b0; u_if.i_we = 4'h0; u_if.i_addr = '0; u_if.i_dat_w = '0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
    checks++; if (u_if.o_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", u_if.o_ack); end
    checks++; if (u_if.o_dat_r !== 32'd0) begin errors++; $display("FAIL rst_dat_r: got %h want 0", u_if.o_dat_r); end
    rst = 1'b0;
    bus_write(A_DATA, 32'h55);
    bus_write(A_DATA, 32'h66);
    repeat (10) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midframe_tx: got %b want 0", tx); end
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL async_rst_tx: got %b want 1", tx); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_read(A_STAT, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL rst_status: got %h want 00000002", r); end
    bus_read(A_DIV, r);
    checks++; if (r !== 32'd434) begin errors++; $display("FAIL rst_div: got %0d want 434", r); end
    repeat (20) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL post_rst_tx: got %b want 1", tx); end
  endtask

  task automatic test_tx_frame();
    logic [31:0] r;
    logic [9:0]  e, o;
    bus_write(A_DIV, 32'd4);
    mon_div = 4;
    mon_en  = 1'b1;
    q_tx_exp.push_back({1'b1, 8'hA5, 1'b0});
    bus_write(A_DATA, 32'hA5);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_before_start: got %b want 1", tx); end
    @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL tx_start_latency: got %b want 0", tx); end
    repeat (38) @(negedge clk);
    bus_read(A_STAT, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL tx_busy_last_cycle: got %h want 00000000", r); end
    bus_read(A_STAT, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL tx_idle_after_frame: got %h want 00000002", r); end
    wait_frames(1, 100);
    checks++;
    if (q_tx_obs.size() < 1) begin errors++; $display("FAIL tx_frame_timeout: got %0d frames want 1", q_tx_obs.size()); end
    while (q_tx_obs.size() > 0 && q_tx_exp.size() > 0) begin
      e = q_tx_exp.pop_front(); o = q_tx_obs.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL tx_frame_bits: got %b want %b", o, e); end
    end
    q_tx_exp.delete();
  endtask

  task automatic test_tx_full();
    logic [31:0] r;
    logic [9:0]  e, o;
    logic [7:0]  b;
    bus_write(A_DIV, 32'd8);
    mon_div = 8;
    q_tx_exp.push_back({1'b1, 8'h10, 1'b0});
    bus_write(A_DATA, 32'h10);
    for (int i = 0; i < 17; i++) begin
      b = 8'h20 + 8'(i);
      if (i < 16) q_tx_exp.push_back({1'b1, b, 1'b0});
      bus_write(A_DATA, {24'd0, b});
      if (i == 14) begin
        bus_read(A_STAT, r);
        checks++; if (r[0] !== 1'b0) begin errors++; $display("FAIL tx_full_early: got %b want 0", r[0]); end
      end
      if (i == 15) begin
        bus_read(A_STAT, r);
        checks++; if (r[0] !== 1'b1) begin errors++; $display("FAIL tx_full_at16: got %b want 1", r[0]); end
      end
    end
    wait_frames(17, 2500);
    checks++;
    if (q_tx_obs.size() < 17) begin errors++; $display("FAIL tx_full_timeout: got %0d frames want 17", q_tx_obs.size()); end
    while (q_tx_obs.size() > 0 && q_tx_exp.size() > 0) begin
      e = q_tx_exp.pop_front(); o = q_tx_obs.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL tx_fifo_order: got %b want %b", o, e); end
    end
    q_tx_exp.delete();
    repeat (200) @(negedge clk);
    checks++; if (q_tx_obs.size() != 0) begin errors++; $display("FAIL tx_dropped_byte_sent: got %0d extra frames want 0", q_tx_obs.size()); end
    q_tx_obs.delete();
  endtask

  task automatic test_rx_good();
    logic [31:0] r;
    logic [7:0]  e;
    bus_write(A_DIV, 32'd8);
    q_rx_exp.push_back(8'h3C);
    send_rx(8'h3C, 1'b1, 8);
    repeat (4) @(negedge clk);
    bus_read(A_STAT, r);
    checks++; if (r !== 32'h106) begin errors++; $display("FAIL rx_status_avail: got %h want 00000106", r); end
    bus_read(A_DATA, r);
    e = q_rx_exp.pop_front();
    checks++; if (r !== {24'd0, e}) begin errors++; $display("FAIL rx_data: got %h want %h", r, {24'd0, e}); end
    bus_read(A_DATA, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL rx_empty_read: got %h want 00000000", r); end
    bus_read(A_STAT, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL rx_status_empty: got %h want 00000002", r); end
  endtask

  task automatic test_rx_errors();
    logic [31:0] r;
    logic [7:0]  b, e;
    send_rx(8'h5A, 1'b0, 8);
    repeat (4) @(negedge clk);
    bus_read(A_STAT, r);
    checks++; if (r !== 32'h12) begin errors++; $display("FAIL rx_frame_err: got %h want 00000012", r); end
    for (int i = 0; i < 17; i++) begin
      b = 8'h40 + 8'(i * 3);
      if (q_rx_exp.size() < 16) q_rx_exp.push_back(b);
      send_rx(b, 1'b1, 8);
    end
    repeat (4) @(negedge clk);
    bus_read(A_STAT, r);
    checks++; if (r !== 32'h101E) begin errors++; $display("FAIL rx_overrun_status: got %h want 0000101e", r); end
    bus_write(A_STAT, 32'h18);
    bus_read(A_STAT, r);
    checks++; if (r !== 32'h1006) begin errors++; $display("FAIL rx_w1c: got %h want 00001006", r); end
    while (q_rx_exp.size() > 0) begin
      e = q_rx_exp.pop_front();
      bus_read(A_DATA, r);
      checks++; if (r !== {24'd0, e}) begin errors++; $display("FAIL rx_fifo_order: got %h want %h", r, {24'd0, e}); end
    end
    bus_read(A_STAT, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL rx_drained: got %h want 00000002", r); end
  endtask

  task automatic test_handshake();
    logic [31:0] r;
    logic [9:0]  e, o;
    logic        exp_ack;
    bus_write(A_DIV, 32'd4);
    mon_div = 4;
    repeat (3) q_tx_exp.push_back({1'b1, 8'h42, 1'b0});
    @(negedge clk);
    u_if.i_addr  = A_DATA;
    u_if.i_we    = 4'h1;
    u_if.i_dat_w = 32'h42;
    u_if.i_stb   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_ack = (i % 2 == 1);
      checks++; if (u_if.o_ack !== exp_ack) begin errors++; $display("FAIL held_stb_ack[%0d]: got %b want %b", i, u_if.o_ack, exp_ack); end
      @(negedge clk);
    end
    u_if.i_stb = 1'b0;
    u_if.i_we  = 4'h0;
    wait_frames(3, 300);
    checks++;
    if (q_tx_obs.size() < 3) begin errors++; $display("FAIL held_stb_timeout: got %0d frames want 3", q_tx_obs.size()); end
    while (q_tx_obs.size() > 0 && q_tx_exp.size() > 0) begin
      e = q_tx_exp.pop_front(); o = q_tx_obs.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL held_stb_frame: got %b want %b", o, e); end
    end
    repeat (100) @(negedge clk);
    checks++; if (q_tx_obs.size() != 0) begin errors++; $display("FAIL held_stb_extra: got %0d extra frames want 0", q_tx_obs.size()); end
    bus_write(A_DIV, 32'd2);
    bus_read(A_DIV, r);
    checks++; if (r !== 32'd4) begin errors++; $display("FAIL div_clamp: got %0d want 4", r); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_tx_full();
    test_rx_good();
    test_rx_errors();
    test_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
